wb_sched: RTL and testbench

WB_SCHED -- requirements
Module: wb_sched

---
 rtl/wb_sched.sv | 160 ++++++++++++++++
 tb/tb_wb_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// ---------------------------------------------------------------------------
// wb_sched : register-file writeback scheduler with issue scoreboard.
//
// Purpose
//   Tracks which architectural registers have an outstanding write (the
//   scoreboard `pending`). It stalls issue when a source or destination
//   register is still in flight. It also arbitrates between the ALU and the
//   load unit for the single register-file write port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rsvEn, rsvIdx            issue stage reserves destination register
//   chkAEn/chkAIdx,
//   chkBEn/chkBIdx           source operands used by the issuing instruction
//   stall                    combinational issue hazard
//   aluReq/aluIdx/aluData    ALU writeback request (held until aluGnt)
//   memReq/memIdx/memData    load writeback request (held until memGnt)
//   aluGnt, memGnt           combinational grants, same cycle as request
//   wbEn, wbIdx, wbData      registered register-file write port
//   pending                  scoreboard, bit n = register n awaiting write
//   err                      sticky: [0] write to R15, [1] write to idle reg
// ---------------------------------------------------------------------------
module wb_sched #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsvEn,
  input  logic [3:0]        rsvIdx,
  input  logic              chkAEn,
  input  logic [3:0]        chkAIdx,
  input  logic              chkBEn,
  input  logic [3:0]        chkBIdx,
  output logic              stall,
  input  logic              aluReq,
  input  logic [3:0]        aluIdx,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memReq,
  input  logic [3:0]        memIdx,
  input  logic [DATA_W-1:0] memData,
  output logic              aluGnt,
  output logic              memGnt,
  output logic              wbEn,
  output logic [3:0]        wbIdx,
  output logic [DATA_W-1:0] wbData,
  output logic [15:0]       pending,
  output logic [1:0]        err
);

  // Index 15 is the PC: never reservable, never written through this port.
  localparam logic [3:0] PC_IDX  = 4'hF;

  // Encoding of the last-granted source.
  localparam logic       SRC_ALU = 1'b0;
  localparam logic       SRC_MEM = 1'b1;

  // State
  logic [14:0]       pend_q,    pend_d;
  logic              last_q,    last_d;
  logic              wb_en_q,   wb_en_d;
  logic [3:0]        wb_idx_q,  wb_idx_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [1:0]        err_q,     err_d;

  // Combinational helpers
  logic [15:0]       pend_full;
  logic              alu_gnt;
  logic              mem_gnt;
  logic              any_gnt;
  logic [3:0]        g_idx;
  logic [DATA_W-1:0] g_data;
  logic              g_is_pc;
  logic              rsv_take;
  logic [15:0]       pend_work;

  // Bit 15 is structurally zero so a lookup of index 15 never reports a hazard.
  assign pend_full = {1'b0, pend_q};

  // Issue hazard: any used operand or the destination still awaiting write.
  assign stall = (chkAEn & pend_full[chkAIdx])
               | (chkBEn & pend_full[chkBIdx])
               | (rsvEn  & pend_full[rsvIdx]);

  // Round-robin on a tie: the source that did not win last time wins now.
  // Grants are suppressed during reset so no request is consumed.
  assign alu_gnt = ~rst & aluReq & (~memReq | (last_q == SRC_MEM));
  assign mem_gnt = ~rst & memReq & (~aluReq | (last_q == SRC_ALU));
  assign any_gnt = alu_gnt | mem_gnt;

  assign aluGnt  = alu_gnt;
  assign memGnt  = mem_gnt;

  assign g_idx   = mem_gnt ? memIdx  : aluIdx;
  assign g_data  = mem_gnt ? memData : aluData;
  assign g_is_pc = (g_idx == PC_IDX);

  // A reservation is only taken when issue actually proceeds.
  assign rsv_take = rsvEn & ~stall & (rsvIdx != PC_IDX);

  always_comb begin
    pend_work = pend_full;
    // The wbEn=1 cycle ends on the register-file write edge; the bit clears
    // there so dependents only issue once the data is readable.
    if (wb_en_q) begin
      pend_work[wb_idx_q] = 1'b0;
    end
    // Applied after the clear so a same-edge reserve of that index wins.
    if (rsv_take) begin
      pend_work[rsvIdx] = 1'b1;
    end
    pend_d = pend_work[14:0];
  end

  always_comb begin
    last_d    = last_q;
    wb_en_d   = 1'b0;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    if (any_gnt) begin
      last_d = mem_gnt ? SRC_MEM : SRC_ALU;
      if (g_is_pc) begin
        // Consumed but dropped: the PC is not writable from here.
        err_d[0] = 1'b1;
      end else begin
        wb_en_d   = 1'b1;
        wb_idx_d  = g_idx;
        wb_data_d = g_data;
        if (!pend_full[g_idx]) begin
          err_d[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      last_q    <= SRC_MEM;
      wb_en_q   <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      err_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      last_q    <= last_d;
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign wbEn    = wb_en_q;
  assign wbIdx   = wb_idx_q;
  assign wbData  = wb_data_q;
  assign pending = pend_full;
  assign err     = err_q;

endmodule

// File: tb/tb_wb_sched.sv
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsvEn;
  logic [3:0]  rsvIdx;
  logic        chkAEn;
  logic [3:0]  chkAIdx;
  logic        chkBEn;
  logic [3:0]  chkBIdx;
  logic        stall;
  logic        aluReq;
  logic [3:0]  aluIdx;
  logic [15:0] aluData;
  logic        memReq;
  logic [3:0]  memIdx;
  logic [15:0] memData;
  logic        aluGnt;
  logic        memGnt;
  logic        wbEn;
  logic [3:0]  wbIdx;
  logic [15:0] wbData;
  logic [15:0] pending;
  logic [1:0]  err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_pend [16];
  bit          m_err0, m_err1;
  bit          m_last_mem;
  bit          m_wbEn;
  logic [3:0]  m_wbIdx;
  logic [15:0] m_wbData;
  bit          g_alu, g_mem;

  always #5 clk = ~clk;

  wb_sched dut (
    .clk(clk), .rst(rst),
    .rsvEn(rsvEn), .rsvIdx(rsvIdx),
    .chkAEn(chkAEn), .chkAIdx(chkAIdx),
    .chkBEn(chkBEn), .chkBIdx(chkBIdx),
    .stall(stall),
    .aluReq(aluReq), .aluIdx(aluIdx), .aluData(aluData),
    .memReq(memReq), .memIdx(memIdx), .memData(memData),
    .aluGnt(aluGnt), .memGnt(memGnt),
    .wbEn(wbEn), .wbIdx(wbIdx), .wbData(wbData),
    .pending(pending), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_err0 = 0; m_err1 = 0; m_last_mem = 1; m_wbEn = 0;
    m_wbIdx = 4'd0; m_wbData = 16'd0;
  endtask

  task automatic drive_idle();
    rsvEn = 0; rsvIdx = 0; chkAEn = 0; chkAIdx = 0; chkBEn = 0; chkBIdx = 0;
    aluReq = 0; aluIdx = 0; aluData = 0; memReq = 0; memIdx = 0; memData = 0;
  endtask

  // One clock cycle: check combinational outputs against the model, clock
  // the edge, advance the model, then check registered outputs.
  task automatic tick();
    bit eS, eA, eM;
    bit np [16];
    logic [3:0]  gi;
    logic [15:0] gd;
    #2;
    eS = (chkAEn && m_pend[chkAIdx]) || (chkBEn && m_pend[chkBIdx]) || (rsvEn && m_pend[rsvIdx]);
    if (rst) begin
      eA = 0; eM = 0;
    end else if (aluReq && memReq) begin
      eA = m_last_mem; eM = !m_last_mem;
    end else begin
      eA = aluReq; eM = memReq;
    end
    chk("stall",  32'(stall),  32'(eS));
    chk("aluGnt", 32'(aluGnt), 32'(eA));
    chk("memGnt", 32'(memGnt), 32'(eM));
    g_alu = eA; g_mem = eM;
    gi = eM ? memIdx : aluIdx;
    gd = eM ? memData : aluData;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      np = m_pend;
      if (m_wbEn) np[m_wbIdx] = 0;
      if (rsvEn && !eS && rsvIdx != 4'd15) np[rsvIdx] = 1;
      if (eA || eM) begin
        m_last_mem = eM;
        if (gi == 4'd15) begin
          m_err0 = 1; m_wbEn = 0;
        end else begin
          if (!m_pend[gi]) m_err1 = 1;
          m_wbEn = 1; m_wbIdx = gi; m_wbData = gd;
        end
      end else begin
        m_wbEn = 0;
      end
      m_pend = np;
    end
    #1;
    chk("wbEn",    32'(wbEn),    32'(m_wbEn));
    chk("wbIdx",   32'(wbIdx),   32'(m_wbIdx));
    chk("wbData",  32'(wbData),  32'(m_wbData));
    chk("pending", 32'(pending), 32'(model_pending()));
    chk("err",     32'(err),     32'({m_err1, m_err0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1;
    g_alu = 0; g_mem = 0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_wbEn",    32'(wbEn),    32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_wbIdx",   32'(wbIdx),   32'd0);
    chk("rst_wbData",  32'(wbData),  32'd0);

    // Requests outstanding during reset are not granted
    aluReq = 1; aluIdx = 4'd1; aluData = 16'h0A01;
    memReq = 1; memIdx = 4'd2; memData = 16'h0B02;
    rsvEn = 1; rsvIdx = 4'd4;
    #2;
    chk("rst_aluGnt", 32'(aluGnt), 32'd0);
    chk("rst_memGnt", 32'(memGnt), 32'd0);
    tick();
    chk("rst_no_rsv", 32'(pending), 32'd0);

    // Tie right after reset: ALU first, then memory, no bubble
    rst = 0; rsvEn = 0;
    #2;
    chk("tie_alu_first", 32'(aluGnt), 32'd1);
    chk("tie_mem_wait",  32'(memGnt), 32'd0);
    tick();
    chk("tie_wb1_en",  32'(wbEn),  32'd1);
    chk("tie_wb1_idx", 32'(wbIdx), 32'd1);
    aluReq = 0;
    #2;
    chk("tie_mem_second", 32'(memGnt), 32'd1);
    tick();
    chk("tie_wb2_en",   32'(wbEn),   32'd1);
    chk("tie_wb2_idx",  32'(wbIdx),  32'd2);
    chk("tie_wb2_data", 32'(wbData), 32'h0B02);
    memReq = 0;
    tick();
    chk("idle_wbEn",     32'(wbEn),   32'd0);
    chk("hold_wbData",   32'(wbData), 32'h0B02);

    // Reserve R3, dependent stalls until writeback completes
    rst = 1; tick(); rst = 0;
    rsvEn = 1; rsvIdx = 4'd3;
    tick();
    rsvEn = 0; chkAEn = 1; chkAIdx = 4'd3;
    #2;
    chk("r3_stall", 32'(stall), 32'd1);
    tick();
    aluReq = 1; aluIdx = 4'd3; aluData = 16'h1234;
    tick();
    aluReq = 0;
    chk("r3_wbEn",   32'(wbEn),   32'd1);
    chk("r3_wbIdx",  32'(wbIdx),  32'd3);
    chk("r3_wbData", 32'(wbData), 32'h1234);
    #2;
    chk("r3_stall_during_wb", 32'(stall), 32'd1);
    tick();
    #2;
    chk("r3_stall_released", 32'(stall), 32'd0);
    tick();
    chkAEn = 0;

    // Reserve R5 on the edge that clears R5: reserve wins
    aluReq = 1; aluIdx = 4'd5; aluData = 16'h5555;
    tick();
    aluReq = 0;
    rsvEn = 1; rsvIdx = 4'd5;
    tick();
    rsvEn = 0;
    chk("r5_reserve_wins", 32'(pending[5]), 32'd1);

    // Reserve an already pending register: stalls, no change
    rsvEn = 1; rsvIdx = 4'd7;
    tick();
    #2;
    chk("r7_stall", 32'(stall), 32'd1);
    tick();
    rsvEn = 0;
    chk("r7_pending", 32'(pending), 32'h00A0);

    // Reset in the cycle after a grant discards the writeback
    aluReq = 1; aluIdx = 4'd7; aluData = 16'h7777;
    tick();
    aluReq = 0; rst = 1;
    tick();
    rst = 0;
    chk("rstmid_wbEn",    32'(wbEn),    32'd0);
    chk("rstmid_pending", 32'(pending), 32'd0);
    chk("rstmid_err",     32'(err),     32'd0);

    // Write to R15: consumed, no write, sticky err[0]
    memReq = 1; memIdx = 4'd15; memData = 16'hFFFF;
    #2;
    chk("pc_memGnt", 32'(memGnt), 32'd1);
    tick();
    memReq = 0;
    chk("pc_wbEn", 32'(wbEn), 32'd0);
    chk("pc_err",  32'(err),  32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("pc_err_sticky", 32'(err), 32'd1);

    // Randomized traffic obeying the hold-until-grant protocol
    rst = 1; tick(); rst = 0;
    g_alu = 0; g_mem = 0;
    for (int c = 0; c < 400; c++) begin
      rsvEn   = ($urandom % 3) == 0;
      rsvIdx  = 4'($urandom_range(0, 15));
      chkAEn  = 1'($urandom % 2);
      chkAIdx = 4'($urandom_range(0, 15));
      chkBEn  = 1'($urandom % 2);
      chkBIdx = 4'($urandom_range(0, 15));
      if (!aluReq || g_alu) begin
        aluReq  = 1'($urandom % 2);
        aluIdx  = 4'($urandom_range(0, 15));
        aluData = 16'($urandom);
      end
      if (!memReq || g_mem) begin
        memReq  = 1'($urandom % 2);
        memIdx  = 4'($urandom_range(0, 15));
        memData = 16'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
